// File: rtl/big_clk_sequencer.sv
// Vector-table sequencer: drives one stimulus per big-clock window of TICK_CYCLES
// cycles and compares the design output against the expected value at each window end.
module big_clk_sequencer #(
  parameter int TICK_CYCLES = 100,
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       num_steps,
  input  logic             load_en,
  input  logic [3:0]       load_addr,
  input  logic [WIDTH-1:0] load_input,
  input  logic [WIDTH-1:0] load_expect,
  input  logic [WIDTH-1:0] output_signal,
  output logic             posedge_big_clk,
  output logic [WIDTH-1:0] input_signal,
  output logic [4:0]       step,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [4:0]       mismatch_count
);

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0] IDX0 = '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [4:0] clamp_steps(input logic [4:0] n);
    if (int'(n) > DEPTH) return 5'(DEPTH);
    return n;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == 5'd31) ? c : c + 5'd1;
  endfunction

  logic [WIDTH-1:0] vec_in_q  [DEPTH];
  logic [WIDTH-1:0] vec_exp_q [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [4:0]       step_q, step_d;
  logic [4:0]       n_q, n_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic             mis_q, mis_d;
  logic [4:0]       cnt_q, cnt_d;

  logic [AW-1:0]    load_idx, step_idx, next_idx;
  logic [4:0]       n_req;
  logic             tbl_we, pulse, cmp_fail;

  assign load_idx = AW'(load_addr);
  assign step_idx = AW'(step_q);
  assign next_idx = AW'(step_q + 5'd1);
  assign n_req    = clamp_steps(num_steps);

  // The table is never reset so vectors survive reset and reruns.
  assign tbl_we = load_en && !reset && (state_q != RUN) && (int'(load_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      vec_in_q[load_idx]  <= load_input;
      vec_exp_q[load_idx] <= load_expect;
    end
  end

  assign pulse    = (state_q == RUN) && (tick_q == TICK_LAST);
  assign cmp_fail = pulse && (output_signal != vec_exp_q[step_idx]);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    n_d     = n_q;
    in_d    = in_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (pulse) begin
          tick_d = '0;
          if (cmp_fail) begin
            mis_d = 1'b1;
            cnt_d = sat_inc(cnt_q);
          end
          if (step_q == n_q - 5'd1) begin
            state_d = DONE;
            in_d    = '0;
          end else begin
            step_d = step_q + 5'd1;
            in_d   = vec_in_q[next_idx];
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new run request.
        if (start) begin
          tick_d = '0;
          step_d = '0;
          n_d    = n_req;
          mis_d  = 1'b0;
          cnt_d  = '0;
          if (n_req == 5'd0) begin
            state_d = DONE;
            in_d    = '0;
          end else begin
            state_d = RUN;
            in_d    = vec_in_q[IDX0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      step_q  <= '0;
      n_q     <= '0;
      in_q    <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      n_q     <= n_d;
      in_q    <= in_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign posedge_big_clk = pulse;
  assign input_signal    = in_q;
  assign step            = step_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign mismatch        = mis_q;
  assign mismatch_count  = cnt_q;

endmodule

// File: doc/big_clk_sequencer.md
BIG_CLK_SEQUENCER -- requirements
Module: big_clk_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100, giving clk cycles per big-clock window, with legal minimum 2.
REQ-002 SHALL have parameter DEPTH, default 16, giving the number of vector table entries.
REQ-003 SHALL have parameter WIDTH, default 11, giving the signal width.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a run.
REQ-007 num_steps  in  5  windows per run; values above DEPTH clamp to DEPTH.
REQ-008 load_en  in  1  write strobe for the vector table.
REQ-009 load_addr  in  4  vector table entry index.
REQ-010 load_input  in  WIDTH  stimulus value for the entry.
REQ-011 load_expect  in  WIDTH  expected design output for the entry.
REQ-012 output_signal  in  WIDTH  output of the design under test.
REQ-013 posedge_big_clk  out  1  one-cycle big-clock pulse.
REQ-014 input_signal  out  WIDTH  stimulus driven to the design.
REQ-015 step  out  5  index of the current window.
REQ-016 busy  out  1  high while in RUN.
REQ-017 done  out  1  high while in DONE.
REQ-018 mismatch  out  1  sticky flag for any compare failure in the run.
REQ-019 mismatch_count  out  5  compare failures in the run, saturating at 31.

Function
REQ-020 SHALL implement three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-021 SHALL write load_input and load_expect to entry load_addr on a clock edge where load_en=1 and state is not RUN; load_en SHALL be ignored in RUN.
REQ-022 On start=1 in IDLE or DONE with clamped num_steps>0, the next cycle SHALL be RUN with tick_cnt=0, step=0, input_signal=vec_in[0], mismatch=0 and mismatch_count=0.
REQ-023 On start=1 with clamped num_steps=0, the next cycle SHALL be DONE with no pulse, and mismatch and mismatch_count SHALL clear.
REQ-024 start SHALL be ignored in RUN.
REQ-025 In RUN, tick_cnt SHALL count 0..TICK_CYCLES-1 and wrap to 0.
REQ-026 posedge_big_clk SHALL be 1 exactly in the cycles where tick_cnt==TICK_CYCLES-1, and 0 at all other times and in all other states.
REQ-027 In each pulse cycle, output_signal SHALL be compared bitwise with vec_exp[step].
REQ-028 On a compare failure, the next cycle SHALL show mismatch=1 and mismatch_count incremented, holding at 31 once reached.
REQ-029 In the cycle after a pulse with step<N-1, where N is the clamped num_steps, step SHALL increment and input_signal SHALL update to vec_in[step+1].
REQ-030 In the cycle after a pulse with step==N-1, state SHALL be DONE, input_signal=0, and step SHALL hold N-1.
REQ-031 The first pulse SHALL occur TICK_CYCLES cycles after the start cycle, with pulses every TICK_CYCLES thereafter, giving N pulses per run.
REQ-032 input_signal SHALL be stable for a whole window and SHALL change only in the cycle after a pulse.
REQ-033 DONE SHALL hold done=1, mismatch and mismatch_count until start or reset.
REQ-034 Vector table contents SHALL persist across runs.

Reset
REQ-035 On reset=1 at any clock edge, including mid-run, the next cycle SHALL be IDLE with every output 0 (posedge_big_clk, input_signal, step, busy, done, mismatch, mismatch_count) and tick_cnt=0.
REQ-036 Reset SHALL NOT clear vector table contents.
REQ-037 Reset SHALL take priority over start and load_en in the same cycle.

Verification
REQ-038 Reset: assert reset for 2 cycles -> all outputs 0, state IDLE.
REQ-039 Loopback: TICK_CYCLES=4; load vec_in=vec_exp={5,-3,999}; num_steps=3; output_signal=input_signal; start at cycle 0 -> pulses at cycles 4, 8 and 12; input_signal 5, then 2045 (-3) from cycle 5, then 999 from cycle 9; done=1 from cycle 13; mismatch=0.
REQ-040 Mismatch: same setup with vec_exp[1]=7 -> mismatch=1 and mismatch_count=1 from cycle 9; a restart then clears both.
REQ-041 Zero/clamp: num_steps=0 -> done=1 the next cycle with no pulse; num_steps=20 -> exactly 16 pulses.
REQ-042 Reset mid-run: reset at cycle 6 of the REQ-039 run -> IDLE at cycle 7, no further pulses; a restart then reproduces REQ-039 using the retained table.
REQ-043 Ignored inputs: load_en and start during RUN -> no table change and no restart; pulse timing identical to REQ-039.
